// File: rtl/sat_slew_limiter.sv
// Serial per-channel clamp and slew-rate limiter for FOC command vectors.
// One channel is processed per cycle. The result is held until downstream accepts it.
module sat_slew_limiter #(
    parameter int N = 16,
    parameter int F = 15,
    parameter int C = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [C*N-1:0]      in_data,
    input  logic signed [N-1:0] max,
    input  logic signed [N-1:0] min,
    input  logic signed [N-1:0] step,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [C*N-1:0]      out_data,
    output logic [C-1:0]        sat_flags,
    output logic [C-1:0]        slew_flags
);

    localparam int CW = (C > 1) ? $clog2(C) : 1;

    if (C < 1) begin : g_bad_c
        $error("sat_slew_limiter: C must be >= 1");
    end
    if (F < 0 || F >= N) begin : g_bad_f
        $error("sat_slew_limiter: F must lie in [0, N-1]");
    end

    typedef enum logic [1:0] {IDLE, PROC, HOLD} state_t;

    state_t                state_reg, state_next;
    logic [CW-1:0]         ch_reg;
    logic [C*N-1:0]        data_reg;
    logic signed [N-1:0]   max_reg, min_reg, step_reg;
    logic                  init_reg;
    logic                  hist_valid_reg;
    logic                  in_ready_reg;
    logic signed [N-1:0]   prev_reg [C];
    logic [N-1:0]          out_reg  [C];
    logic                  sat_reg  [C];
    logic                  slew_reg [C];

    logic                  accept;
    logic                  last_ch;
    logic                  proc_wr;

    assign accept  = (state_reg == IDLE) && in_ready_reg && in_valid;
    assign last_ch = (ch_reg == CW'(C - 1));
    assign proc_wr = (state_reg == PROC);

    assign in_ready  = in_ready_reg;
    assign out_valid = (state_reg == HOLD);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)    state_next = PROC;
            PROC:    if (last_ch)   state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Datapath for the channel currently addressed by ch_reg
    logic signed [N-1:0] x, c, y, prev;
    logic signed [N:0]   c_ext, prev_ext, d, s, up, dn;
    logic                bypass;

    always_comb begin
        x        = data_reg[ch_reg*N +: N];
        prev     = prev_reg[ch_reg];
        if (x > max_reg)      c = max_reg;
        else if (x < min_reg) c = min_reg;
        else                  c = x;
        c_ext    = {c[N-1], c};
        prev_ext = {prev[N-1], prev};
        d        = c_ext - prev_ext;
        s        = step_reg[N-1] ? '0 : {1'b0, step_reg};
        up       = prev_ext + s;
        dn       = prev_ext - s;
        bypass   = !hist_valid_reg || init_reg;
        // y stays between prev and c, so dropping the extension bit never wraps
        if (bypass)      y = c;
        else if (d > s)  y = up[N-1:0];
        else if (d < -s) y = dn[N-1:0];
        else             y = c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            in_ready_reg   <= 1'b0;
            ch_reg         <= '0;
            data_reg       <= '0;
            max_reg        <= '0;
            min_reg        <= '0;
            step_reg       <= '0;
            init_reg       <= 1'b0;
            hist_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next == IDLE);
            if (accept) begin
                data_reg <= in_data;
                max_reg  <= max;
                min_reg  <= min;
                step_reg <= step;
                init_reg <= init;
                ch_reg   <= '0;
            end else if (proc_wr) begin
                ch_reg <= ch_reg + 1'b1;
            end
            if (proc_wr && last_ch) begin
                hist_valid_reg <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < C; gi++) begin : g_ch
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prev_reg[gi] <= '0;
                out_reg[gi]  <= '0;
                sat_reg[gi]  <= 1'b0;
                slew_reg[gi] <= 1'b0;
            end else if (proc_wr && (ch_reg == CW'(gi))) begin
                prev_reg[gi] <= y;
                out_reg[gi]  <= y;
                sat_reg[gi]  <= (c != x);
                slew_reg[gi] <= (y != c);
            end
        end
        assign out_data[gi*N +: N] = out_reg[gi];
        assign sat_flags[gi]       = sat_reg[gi];
        assign slew_flags[gi]      = slew_reg[gi];
    end

endmodule
